// File: rtl/seg_disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller.
//   Register map addresses, CTRL field positions, blank pin pattern and the
//   hex-nibble to segment decoder (active-high, bit order g..a).
package seg_disp_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_MODE     = 8'h01;
  localparam logic [7:0] ADDR_BLINK    = 8'h02;
  localparam logic [7:0] ADDR_STATUS   = 8'h03;
  localparam logic [7:0] ADDR_VAL_BASE = 8'h10;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_BRIGHT_LSB = 4;
  localparam int unsigned BRIGHT_W        = 4;
  localparam logic [7:0]  CTRL_RESET      = 8'hF1;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Hex nibble to active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_disp_scan.sv
// Scan timer for the display multiplexer.
//   Free-running slot counter, digit index, brightness phase compare,
//   anti-ghost blank on slot start and (with SEG_DISP_BLINK_EN) blink gating.
// Ports:
//   clk, reset        clock, async active-high reset
//   enable_i          display enable
//   bright_i          brightness level 0..15
//   blink_mask_i      per-digit blink enable (SEG_DISP_BLINK_EN builds only)
//   scan_idx_o        digit currently being scanned
//   slot_active_c_o   combinational: current digit should be driven this cycle
module seg_disp_scan
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SCAN_DIV_LOG2 = 10,
  parameter int unsigned BLINK_LOG2    = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_i,
  input  logic [BRIGHT_W-1:0] bright_i,
`ifdef SEG_DISP_BLINK_EN
  input  logic [7:0]          blink_mask_i,
`endif
  output logic [2:0]          scan_idx_o,
  output logic                slot_active_c_o
);

  localparam int unsigned CNT_W    = SCAN_DIV_LOG2;
  localparam logic [2:0]  LAST_IDX = 3'(NUM_DIGITS - 1);

  if (SCAN_DIV_LOG2 < 4 || BLINK_LOG2 < 1) begin : g_param_check
    $error("seg_disp_scan: SCAN_DIV_LOG2 must be >= 4 and BLINK_LOG2 >= 1");
  end

  logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [2:0]          scan_idx_q, scan_idx_d;
  logic [BRIGHT_W-1:0] phase;
  logic                blink_off;

  // Slot counter wraps into the next digit
  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == '1) begin
      scan_idx_d = (scan_idx_q == LAST_IDX) ? 3'd0 : scan_idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

`ifdef SEG_DISP_BLINK_EN
  localparam int unsigned BLINK_W = BLINK_LOG2 + 1;
  logic [BLINK_W-1:0] blink_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
    end
  end

  assign blink_off = blink_cnt_q[BLINK_LOG2] & blink_mask_i[scan_idx_q];
`else
  assign blink_off = 1'b0;
`endif

  // Top bits of the slot counter form the 16-level PWM phase
  assign phase = scan_cnt_q[CNT_W-1 -: BRIGHT_W];

  // Count 0 is the anti-ghost blank cycle between digits
  assign slot_active_c_o = enable_i && (scan_cnt_q != '0) &&
                           (phase <= bright_i) && !blink_off;
  assign scan_idx_o      = scan_idx_q;

endmodule

// File: rtl/seg_disp_mux_ctrl.sv
// Local-bus slave driving a multiplexed bank of 7-segment digits.
//   Holds the register file, bus read/write logic, per-digit hex/raw decode
//   and the registered display pin drivers. Optional blink feature is built
//   when SEG_DISP_BLINK_EN is defined.
// Ports:
//   clk, reset            clock, async active-high reset
//   addr, cs, req, rnw    bus address/select/request/direction (1=read)
//   wr_data, rd_data      bus write data in, registered read data out
//   rdy                   req delayed by one clock
//   segments_             {dp,g,f,e,d,c,b,a}, active low
//   digit_enable_         one-hot-low digit select
module seg_disp_mux_ctrl
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SCAN_DIV_LOG2 = 10,
  parameter int unsigned BLINK_LOG2    = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            addr,
  input  logic                  cs,
  input  logic                  req,
  input  logic                  rnw,
  input  logic [7:0]            wr_data,
  output logic [7:0]            rd_data,
  output logic                  rdy,
  output logic [7:0]            segments_,
  output logic [NUM_DIGITS-1:0] digit_enable_
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_param_check
    $error("seg_disp_mux_ctrl: NUM_DIGITS must be 1..8");
  end

  localparam logic [8:0] DIGIT_ONE_HOT = 9'(1) << NUM_DIGITS;
  localparam logic [7:0] DIGIT_MASK    = 8'(DIGIT_ONE_HOT - 9'd1);
  localparam logic [3:0] NUM_DIGITS_L  = 4'(NUM_DIGITS);

  logic                  wr_c, rd_c, val_hit_c;
  logic                  en_q;
  logic [BRIGHT_W-1:0]   bright_q;
  logic [7:0]            mode_q;
  logic [7:0]            val_q [8];
  logic [2:0]            scan_idx;
  logic                  slot_active_c;
  logic [7:0]            cur_val_c;
  logic [6:0]            seg7_c;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  rdy_q;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;

  assign wr_c      = cs & req & ~rnw;
  assign rd_c      = cs & req & rnw;
  assign val_hit_c = (addr[7:3] == ADDR_VAL_BASE[7:3]) &&
                     ({1'b0, addr[2:0]} < NUM_DIGITS_L);

  // Register file; MODE bits beyond the populated digits stay zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= CTRL_RESET[CTRL_EN_BIT];
      bright_q <= CTRL_RESET[CTRL_BRIGHT_LSB +: BRIGHT_W];
      mode_q   <= '0;
      for (int i = 0; i < 8; i++) val_q[i] <= '0;
    end else if (wr_c) begin
      if (addr == ADDR_CTRL) begin
        en_q     <= wr_data[CTRL_EN_BIT];
        bright_q <= wr_data[CTRL_BRIGHT_LSB +: BRIGHT_W];
      end
      if (addr == ADDR_MODE) mode_q <= wr_data & DIGIT_MASK;
      if (val_hit_c) val_q[addr[2:0]] <= wr_data;
    end
  end

`ifdef SEG_DISP_BLINK_EN
  logic [7:0] blink_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q <= '0;
    end else if (wr_c && addr == ADDR_BLINK) begin
      blink_q <= wr_data & DIGIT_MASK;
    end
  end
`endif

  seg_disp_scan #(
    .NUM_DIGITS    (NUM_DIGITS),
    .SCAN_DIV_LOG2 (SCAN_DIV_LOG2),
    .BLINK_LOG2    (BLINK_LOG2)
  ) u_scan (
    .clk             (clk),
    .reset           (reset),
    .enable_i        (en_q),
    .bright_i        (bright_q),
`ifdef SEG_DISP_BLINK_EN
    .blink_mask_i    (blink_q),
`endif
    .scan_idx_o      (scan_idx),
    .slot_active_c_o (slot_active_c)
  );

  // Read mux: rd_data holds between reads, unmapped addresses return zero
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_c) begin
      rd_data_d = 8'h00;
      if (addr == ADDR_CTRL) begin
        rd_data_d = {bright_q, 3'b000, en_q};
      end else if (addr == ADDR_MODE) begin
        rd_data_d = mode_q;
`ifdef SEG_DISP_BLINK_EN
      end else if (addr == ADDR_BLINK) begin
        rd_data_d = blink_q;
`endif
      end else if (addr == ADDR_STATUS) begin
        rd_data_d = {5'b00000, scan_idx};
      end else if (val_hit_c) begin
        rd_data_d = val_q[addr[2:0]];
      end
    end
  end

  // Segment decode for the digit under scan
  always_comb begin
    cur_val_c = val_q[scan_idx];
    seg7_c    = mode_q[scan_idx] ? cur_val_c[6:0] : hex_to_seg(cur_val_c[3:0]);
    seg_d     = SEG_BLANK;
    den_d     = '1;
    if (slot_active_c) begin
      seg_d = ~{cur_val_c[7], seg7_c};
      den_d = ~(NUM_DIGITS'(1) << scan_idx);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
      rdy_q     <= 1'b0;
      seg_q     <= SEG_BLANK;
      den_q     <= '1;
    end else begin
      rd_data_q <= rd_data_d;
      rdy_q     <= req;
      seg_q     <= seg_d;
      den_q     <= den_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign rdy           = rdy_q;
  assign segments_     = seg_q;
  assign digit_enable_ = den_q;

endmodule

// File: tb/tb_seg_disp_mux_ctrl.sv
// Self-checking bench for seg_disp_mux_ctrl (4 digits, 16-clock slots).
module tb_seg_disp_mux_ctrl;

  localparam int unsigned N    = 4;
  localparam int unsigned SDL  = 4;
  localparam int unsigned BL   = 6;
  localparam int unsigned SLOT = 1 << SDL;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   addr = 8'h00;
  logic         cs = 1'b0;
  logic         req = 1'b0;
  logic         rnw = 1'b1;
  logic [7:0]   wr_data = 8'h00;
  logic [7:0]   rd_data;
  logic         rdy;
  logic [7:0]   segments_;
  logic [N-1:0] digit_enable_;

  always #5 clk = ~clk;

  seg_disp_mux_ctrl #(
    .NUM_DIGITS    (N),
    .SCAN_DIV_LOG2 (SDL),
    .BLINK_LOG2    (BL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .addr          (addr),
    .cs            (cs),
    .req           (req),
    .rnw           (rnw),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .rdy           (rdy),
    .segments_     (segments_),
    .digit_enable_ (digit_enable_)
  );

  typedef struct {
    logic [7:0]   seg;
    logic [N-1:0] den;
    logic [7:0]   rd;
    logic         rdy;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic       rnw;
    logic [7:0] wd;
    logic       chk;
    logic [7:0] exp_rd;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl [20];

  int checks = 0;
  int failures = 0;

  logic [6:0] hex_tbl [16];

  // Reference model of the register file and scan timer
  int unsigned m_cnt, m_idx;
  logic        m_en;
  logic [3:0]  m_bright;
  logic [7:0]  m_mode, m_blink, m_rd;
  logic [7:0]  m_val [N];
  logic [BL:0] m_bcnt;

  logic [7:0]  w_exp [N];
  int          w_seen [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_en = 1'b1; m_bright = 4'hF;
    m_mode = 8'h00; m_blink = 8'h00; m_rd = 8'h00; m_bcnt = '0;
    for (int i = 0; i < N; i++) m_val[i] = 8'h00;
    sb_q.delete();
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'h00) return {m_bright, 3'b000, m_en};
    if (a == 8'h01) return m_mode;
`ifdef SEG_DISP_BLINK_EN
    if (a == 8'h02) return m_blink;
`endif
    if (a == 8'h03) return 8'(m_idx);
    if (int'(a) >= 16 && int'(a) < 16 + N) return m_val[int'(a) - 16];
    return 8'h00;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h00) begin
      m_en = d[0];
      m_bright = d[7:4];
    end else if (a == 8'h01) begin
      m_mode = d & 8'h0F;
    end else if (a == 8'h02) begin
`ifdef SEG_DISP_BLINK_EN
      m_blink = d & 8'h0F;
`endif
    end else if (int'(a) >= 16 && int'(a) < 16 + N) begin
      m_val[int'(a) - 16] = d;
    end
  endtask

  // One clock: predict the registered outputs, clock, then compare
  task automatic step();
    exp_t e;
    logic [7:0] v;
    logic [6:0] s7;
    logic act, boff;
    int unsigned ph;
    v    = m_val[m_idx];
    s7   = m_mode[m_idx] ? v[6:0] : hex_tbl[v[3:0]];
    ph   = m_cnt >> (SDL - 4);
    boff = 1'b0;
`ifdef SEG_DISP_BLINK_EN
    boff = m_bcnt[BL] && m_blink[m_idx];
`endif
    act   = m_en && (m_cnt != 0) && (ph <= m_bright) && !boff;
    e.seg = act ? ~{v[7], s7} : 8'hFF;
    e.den = act ? ~(N'(1) << m_idx) : '1;
    if (cs && req && rnw) m_rd = model_read(addr);
    e.rd  = m_rd;
    e.rdy = req;
    sb_q.push_back(e);
    @(posedge clk);
    if (cs && req && !rnw) model_write(addr, wr_data);
    m_bcnt = m_bcnt + 1'b1;
    if (m_cnt == SLOT - 1) begin
      m_cnt = 0;
      m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
    end else begin
      m_cnt++;
    end
    #1;
    e = sb_q.pop_front();
    check("segments_", 32'(segments_), 32'(e.seg));
    check("digit_enable_", 32'(digit_enable_), 32'(e.den));
    check("rd_data", 32'(rd_data), 32'(e.rd));
    check("rdy", 32'(rdy), 32'(e.rdy));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic bus_op(input logic [7:0] a, input logic r, input logic [7:0] d);
    addr = a; rnw = r; wr_data = d; cs = 1'b1; req = 1'b1;
    step();
    cs = 1'b0; req = 1'b0; rnw = 1'b1;
  endtask

  // Step n clocks, tallying active cycles per digit and checking their segments
  task automatic watch(input int n);
    for (int d = 0; d < N; d++) w_seen[d] = 0;
    repeat (n) begin
      step();
      for (int d = 0; d < N; d++) begin
        if (digit_enable_ == ~(N'(1) << d)) begin
          w_seen[d]++;
          check($sformatf("digit%0d_segs", d), 32'(segments_), 32'(w_exp[d]));
        end
      end
    end
  endtask

  initial begin
    int cnt;
    bit found;
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    tbl[0]  = '{8'h11, 1'b0, 8'h8A, 1'b0, 8'h00};
    tbl[1]  = '{8'h11, 1'b1, 8'h00, 1'b1, 8'h8A};
    tbl[2]  = '{8'h01, 1'b0, 8'h04, 1'b0, 8'h00};
    tbl[3]  = '{8'h12, 1'b0, 8'h49, 1'b0, 8'h00};
    tbl[4]  = '{8'h01, 1'b1, 8'h00, 1'b1, 8'h04};
    tbl[5]  = '{8'h00, 1'b1, 8'h00, 1'b1, 8'hF1};
    tbl[6]  = '{8'h12, 1'b1, 8'h00, 1'b1, 8'h49};
    tbl[7]  = '{8'h01, 1'b0, 8'hFF, 1'b0, 8'h00};
    tbl[8]  = '{8'h01, 1'b1, 8'h00, 1'b1, 8'h0F};
    tbl[9]  = '{8'h01, 1'b0, 8'h04, 1'b0, 8'h00};
    tbl[10] = '{8'h02, 1'b0, 8'hF1, 1'b0, 8'h00};
`ifdef SEG_DISP_BLINK_EN
    tbl[11] = '{8'h02, 1'b1, 8'h00, 1'b1, 8'h01};
`else
    tbl[11] = '{8'h02, 1'b1, 8'h00, 1'b1, 8'h00};
`endif
    tbl[12] = '{8'h02, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[13] = '{8'h14, 1'b1, 8'h00, 1'b1, 8'h00};
    tbl[14] = '{8'h7F, 1'b1, 8'h00, 1'b1, 8'h00};
    tbl[15] = '{8'h03, 1'b0, 8'hFF, 1'b0, 8'h00};
    tbl[16] = '{8'h00, 1'b1, 8'h00, 1'b1, 8'hF1};
    tbl[17] = '{8'h03, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[18] = '{8'h14, 1'b0, 8'h55, 1'b0, 8'h00};
    tbl[19] = '{8'h14, 1'b1, 8'h00, 1'b1, 8'h00};

    // Reset values
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_data", 32'(rd_data), 32'h00);
    check("reset_rdy", 32'(rdy), 32'h0);
    check("reset_segments", 32'(segments_), 32'hFF);
    check("reset_digit_enable", 32'(digit_enable_), 32'hF);
    reset = 1'b0;

    // Default scan: every digit shows hex 0, 15 active cycles per slot
    for (int d = 0; d < N; d++) w_exp[d] = 8'hC0;
    watch(80);
    check("scan_seen_d0", 32'(w_seen[0]), 32'd30);
    check("scan_seen_d1", 32'(w_seen[1]), 32'd15);
    check("scan_seen_d2", 32'(w_seen[2]), 32'd15);
    check("scan_seen_d3", 32'(w_seen[3]), 32'd15);

    // Register access vectors
    for (int i = 0; i < 20; i++) begin
      bus_op(tbl[i].a, tbl[i].rnw, tbl[i].wd);
      if (tbl[i].rnw) begin
        check($sformatf("tbl%0d_rdy", i), 32'(rdy), 32'h1);
        if (tbl[i].chk) check($sformatf("tbl%0d_rd", i), 32'(rd_data), 32'(tbl[i].exp_rd));
      end
      idle(2);
    end

    // Digit1 hex A with dp, digit2 raw 0x49
    w_exp = '{8'hC0, 8'h08, 8'hB6, 8'hC0};
    watch(SLOT * N);
    for (int d = 0; d < N; d++) check($sformatf("disp_seen_d%0d", d), 32'(w_seen[d]), 32'd15);

    // Hex decode sweep on digits 0 and 3 (digit3 carries junk in bits 6:4)
    for (int h = 0; h < 16; h++) begin
      bus_op(8'h10, 1'b0, 8'(h));
      bus_op(8'h13, 1'b0, {h[0], 3'b101, 4'(15 - h)});
      idle(SLOT * N);
    end

    // Brightness 3: active for scan_cnt 1..3 of each slot
    bus_op(8'h00, 1'b0, 8'h31);
    idle(2);
    cnt = 0;
    repeat (2 * SLOT) begin
      step();
      if (digit_enable_ != '1) cnt++;
    end
    check("bright3_active_cycles", 32'(cnt), 32'd6);

    // Disabled: pins stay off while STATUS keeps moving
    bus_op(8'h00, 1'b0, 8'h00);
    idle(1);
    cnt = 0;
    repeat (40) begin
      step();
      if (digit_enable_ != '1 || segments_ != 8'hFF) cnt++;
    end
    check("disabled_active_cycles", 32'(cnt), 32'd0);
    bus_op(8'h03, 1'b1, 8'h00);
    idle(SLOT - 1);
    bus_op(8'h03, 1'b1, 8'h00);
    bus_op(8'h00, 1'b0, 8'hF1);
    idle(2);

    // Blink digit 0
    bus_op(8'h02, 1'b0, 8'h01);
    idle(2);
    w_exp = '{8'h8E, 8'h08, 8'hB6, 8'h40};
    watch(256);
`ifdef SEG_DISP_BLINK_EN
    check("blink_seen_d0", 32'(w_seen[0]), 32'd30);
`else
    check("blink_seen_d0", 32'(w_seen[0]), 32'd60);
`endif
    check("blink_seen_d1", 32'(w_seen[1]), 32'd60);
    bus_op(8'h02, 1'b0, 8'h00);

    // Asynchronous reset while a digit is lit
    bus_op(8'h11, 1'b1, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 4 * SLOT && !found; i++) begin
      step();
      if (digit_enable_ != '1) found = 1'b1;
    end
    check("wait_active_slot", 32'(found), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_segments", 32'(segments_), 32'hFF);
    check("async_reset_digit_enable", 32'(digit_enable_), 32'hF);
    check("async_reset_rd_data", 32'(rd_data), 32'h00);
    check("async_reset_rdy", 32'(rdy), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle(20);
    bus_op(8'h11, 1'b1, 8'h00);
    check("post_reset_val1", 32'(rd_data), 32'h00);
    bus_op(8'h00, 1'b1, 8'h00);
    check("post_reset_ctrl", 32'(rd_data), 32'hF1);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
